// File: rtl/bsg_mem_1rw_sync_mask_write_bit_arb_if.sv
// Request/response and memory-side bundle for the two-port arbiter.
// Arbiter takes the slave modport; requesters/memory take master.
interface bsg_mem_1rw_sync_mask_write_bit_arb_if #(
  parameter int width_p       = 16,
  parameter int els_p         = 16,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
);
  logic [1:0]                 v_i;
  logic [1:0]                 w_i;
  logic [2*addr_width_lp-1:0] addr_i;
  logic [2*width_p-1:0]       data_i;
  logic [2*width_p-1:0]       w_mask_i;
  logic [1:0]                 ready_o;
  logic [1:0]                 resp_v_o;
  logic [2*width_p-1:0]       resp_data_o;
  logic [1:0]                 resp_yumi_i;
  logic                       mem_v_o;
  logic                       mem_w_o;
  logic [addr_width_lp-1:0]   mem_addr_o;
  logic [width_p-1:0]         mem_data_o;
  logic [width_p-1:0]         mem_w_mask_o;
  logic [width_p-1:0]         mem_data_i;
  logic                       init_done_o;

  modport slave (
    input  v_i, w_i, addr_i, data_i, w_mask_i,
    input  resp_yumi_i, mem_data_i,
    output ready_o, resp_v_o, resp_data_o,
    output mem_v_o, mem_w_o, mem_addr_o,
    output mem_data_o, mem_w_mask_o, init_done_o
  );

  modport master (
    output v_i, w_i, addr_i, data_i, w_mask_i,
    output resp_yumi_i, mem_data_i,
    input  ready_o, resp_v_o, resp_data_o,
    input  mem_v_o, mem_w_o, mem_addr_o,
    input  mem_data_o, mem_w_mask_o, init_done_o
  );
endinterface

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_arb.sv
// Round-robin share of one 1rw sync masked-write memory by two ports.
// Define BSG_MEM_1RW_ARB_INIT_EN to zero-sweep the array after reset.
module bsg_mem_1rw_sync_mask_write_bit_arb #(
  parameter int width_p       = 16,
  parameter int els_p         = 16,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input logic clk_i,
  input logic reset_i,
  bsg_mem_1rw_sync_mask_write_bit_arb_if.slave bus
);
  localparam int aw = addr_width_lp;

  logic                      run;
  logic                      init_v;
  logic [aw-1:0]             init_addr;
  logic [1:0]                pend;
  logic [1:0]                elig;
  logic [1:0]                gnt;
  logic                      sel;
  logic                      rr_q, rr_d;
  logic [1:0]                inflight_q, inflight_d;
  logic [1:0]                held_q, held_d;
  logic [1:0][width_p-1:0]   data_q, data_d;
  logic [1:0][width_p-1:0]   resp_data;

`ifdef BSG_MEM_1RW_ARB_INIT_EN
  typedef enum logic {S_INIT, S_RUN} state_e;
  state_e        state_q, state_d;
  logic [aw-1:0] cnt_q, cnt_d;

  // Init sweep state and address counter
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One address per cycle, RUN after the last one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == aw'(els_p - 1)) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    end
  end

  assign run       = (state_q == S_RUN);
  assign init_v    = ~reset_i & (state_q == S_INIT);
  assign init_addr = cnt_q;
`else
  assign run       = 1'b1;
  assign init_v    = 1'b0;
  assign init_addr = '0;
`endif

  assign bus.init_done_o = run;

  // Eligibility and round-robin pick; reads wait for own response
  always_comb begin
    pend = inflight_q | held_q;
    for (int p = 0; p < 2; p++) begin
      elig[p] = run & ~reset_i & bus.v_i[p]
              & (bus.w_i[p] | ~pend[p]);
    end
    gnt[0] = elig[0] & (~elig[1] | ~rr_q);
    gnt[1] = elig[1] & (~elig[0] |  rr_q);
  end

  assign sel         = gnt[1];
  assign bus.ready_o = gnt;

  // Memory command: init sweep, else the winner's fields
  always_comb begin
    bus.mem_v_o      = 1'b0;
    bus.mem_w_o      = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_data_o   = '0;
    bus.mem_w_mask_o = '0;
    if (init_v) begin
      bus.mem_v_o      = 1'b1;
      bus.mem_w_o      = 1'b1;
      bus.mem_addr_o   = init_addr;
      bus.mem_w_mask_o = '1;
    end else if (|gnt) begin
      bus.mem_v_o = 1'b1;
      bus.mem_w_o = bus.w_i[sel];
      bus.mem_addr_o = sel ? bus.addr_i[2*aw-1:aw]
                           : bus.addr_i[aw-1:0];
      bus.mem_data_o = sel ? bus.data_i[2*width_p-1:width_p]
                           : bus.data_i[width_p-1:0];
      bus.mem_w_mask_o = sel ? bus.w_mask_i[2*width_p-1:width_p]
                             : bus.w_mask_i[width_p-1:0];
    end
  end

  // Pointer update and per-port response capture/release
  always_comb begin
    rr_d = rr_q;
    if (|gnt) rr_d = ~sel;
    for (int p = 0; p < 2; p++) begin
      inflight_d[p] = gnt[p] & ~bus.w_i[p];
      held_d[p]     = held_q[p];
      data_d[p]     = data_q[p];
      if (inflight_q[p] & ~bus.resp_yumi_i[p]) begin
        held_d[p] = 1'b1;
        data_d[p] = bus.mem_data_i;
      end else if (bus.resp_yumi_i[p]) begin
        held_d[p] = 1'b0;
      end
    end
  end

  // Arbiter and response-holding state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_q       <= 1'b0;
      inflight_q <= '0;
      held_q     <= '0;
      data_q     <= '0;
    end else begin
      rr_q       <= rr_d;
      inflight_q <= inflight_d;
      held_q     <= held_d;
      data_q     <= data_d;
    end
  end

  // Fresh read data comes straight from memory, then from the register
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      resp_data[p] = inflight_q[p] ? bus.mem_data_i : data_q[p];
    end
  end

  assign bus.resp_v_o    = inflight_q | held_q;
  assign bus.resp_data_o = {resp_data[1], resp_data[0]};
endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_arb.sv
// Randomized scoreboard bench for the two-port memory arbiter.
// Honours BSG_MEM_1RW_ARB_INIT_EN the same way as the design.
module tb_bsg_mem_1rw_sync_mask_write_bit_arb;
  localparam int W  = 16;
  localparam int E  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bsg_mem_1rw_sync_mask_write_bit_arb_if #(
    .width_p(W), .els_p(E)
  ) bus ();

  bsg_mem_1rw_sync_mask_write_bit_arb #(
    .width_p(W), .els_p(E)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .bus(bus.slave)
  );

  // Behavioural synchronous memory driven by the arbiter
  logic [W-1:0] mem [E];
  logic [W-1:0] mem_q;
  assign bus.mem_data_i = mem_q;
  always @(posedge clk) begin
    if (bus.mem_v_o) begin
      if (bus.mem_w_o)
        mem[bus.mem_addr_o] <=
          (mem[bus.mem_addr_o] & ~bus.mem_w_mask_o)
          | (bus.mem_data_o & bus.mem_w_mask_o);
      else
        mem_q <= mem[bus.mem_addr_o];
    end
  end

  int tests = 0;
  int fails = 0;
  logic [W-1:0] refmem [E];
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  bit   pref;
  bit   mon_en;
  int   pct0, pct1;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, a, e, $time);
    end
  endtask

  logic [1:0]    pend, elig, exp_rdy, y;
  int            win;
  logic          ew;
  logic [AW-1:0] ea;
  logic [W-1:0]  ed, em;

  // Monitor: arbitration model, command check, response scoreboard
  always @(negedge clk) begin
    if (!mon_en) begin
      bus.resp_yumi_i = 2'b00;
    end else begin
      pend = {q1.size() != 0, q0.size() != 0};
      elig = bus.v_i & (bus.w_i | ~pend);
      if (elig == 2'b11) exp_rdy = pref ? 2'b10 : 2'b01;
      else               exp_rdy = elig;
      chk("ready", bus.ready_o, exp_rdy);
      chk("mem_v", bus.mem_v_o, |exp_rdy);
      if (exp_rdy != 2'b00) begin
        win = exp_rdy[1] ? 1 : 0;
        ew = bus.w_i[win];
        ea = win ? bus.addr_i[2*AW-1:AW] : bus.addr_i[AW-1:0];
        ed = win ? bus.data_i[2*W-1:W] : bus.data_i[W-1:0];
        em = win ? bus.w_mask_i[2*W-1:W] : bus.w_mask_i[W-1:0];
        chk("mem_w", bus.mem_w_o, ew);
        chk("mem_addr", bus.mem_addr_o, ea);
        chk("mem_data", bus.mem_data_o, ed);
        chk("mem_mask", bus.mem_w_mask_o, em);
      end
      chk("resp_v", bus.resp_v_o, pend);
      if (pend[0])
        chk("resp_data0", bus.resp_data_o[W-1:0], q0[0]);
      if (pend[1])
        chk("resp_data1", bus.resp_data_o[2*W-1:W], q1[0]);
      y[0] = pend[0] && ($urandom_range(99) < pct0);
      y[1] = pend[1] && ($urandom_range(99) < pct1);
      bus.resp_yumi_i = y;
      if (y[0]) void'(q0.pop_front());
      if (y[1]) void'(q1.pop_front());
      if (exp_rdy != 2'b00) begin
        if (ew) refmem[ea] = (refmem[ea] & ~em) | (ed & em);
        else if (win == 1) q1.push_back(refmem[ea]);
        else q0.push_back(refmem[ea]);
        pref = (win == 0);
      end
    end
  end

  task automatic set_in(input logic [1:0] v, input logic [1:0] w,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [W-1:0] d1, input logic [W-1:0] m1);
    bus.v_i      = v;
    bus.w_i      = w;
    bus.addr_i   = {a1, a0};
    bus.data_i   = {d1, W'($urandom)};
    bus.w_mask_i = {m1, W'($urandom)};
  endtask

  task automatic post_reset();
`ifdef BSG_MEM_1RW_ARB_INIT_EN
    set_in(2'b11, 2'b00, '0, '0, '0, '0);
    for (int i = 0; i < E; i++) begin
      @(negedge clk);
      chk("init_v", bus.mem_v_o, 1'b1);
      chk("init_w", bus.mem_w_o, 1'b1);
      chk("init_addr", bus.mem_addr_o, i);
      chk("init_data", bus.mem_data_o, 0);
      chk("init_mask", bus.mem_w_mask_o, 16'hffff);
      chk("init_ready", bus.ready_o, 2'b00);
      chk("init_done_lo", bus.init_done_o, 1'b0);
    end
    @(negedge clk);
    chk("init_done_hi", bus.init_done_o, 1'b1);
    chk("run_ready", bus.ready_o, 2'b01);
    bus.v_i = 2'b00;
    for (int i = 0; i < E; i++) refmem[i] = '0;
`else
    set_in(2'b01, 2'b00, '0, '0, '0, '0);
    @(negedge clk);
    chk("first_ready", bus.ready_o, 2'b01);
    chk("init_done", bus.init_done_o, 1'b1);
    bus.v_i = 2'b00;
`endif
    pref = 1'b0;
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      set_in(2'($urandom), 2'($urandom),
             AW'($urandom_range(7)), AW'($urandom_range(7)),
             W'($urandom), W'($urandom));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.v_i = 2'b00;
    end
  endtask

  task automatic reset_checks();
    @(negedge clk);
    chk("rst_ready", bus.ready_o, 2'b00);
    chk("rst_resp_v", bus.resp_v_o, 2'b00);
    chk("rst_mem_v", bus.mem_v_o, 1'b0);
    chk("rst_mem_w", bus.mem_w_o, 1'b0);
`ifdef BSG_MEM_1RW_ARB_INIT_EN
    chk("rst_init_done", bus.init_done_o, 1'b0);
`else
    chk("rst_init_done", bus.init_done_o, 1'b1);
`endif
  endtask

  initial begin
    rst = 1'b1;
    mon_en = 1'b0;
    pct0 = 60;
    pct1 = 60;
    pref = 1'b0;
    mem_q = '0;
    for (int i = 0; i < E; i++) begin
      mem[i] = '0;
      refmem[i] = '0;
    end
    set_in(2'b11, 2'b00, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    reset_checks();
    chk("rst_resp_data", bus.resp_data_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    post_reset();
    @(posedge clk); #1;
    mon_en = 1'b1;

    rand_cycles(1500);

    pct0 = 100;
    pct1 = 100;
    idle_cycles(4);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      set_in(2'b11, 2'b00,
             AW'($urandom_range(15)), AW'($urandom_range(15)),
             '0, '0);
    end

    idle_cycles(4);
    pct0 = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      set_in(2'b11, 2'b00, AW'(3), AW'(i), '0, '0);
    end
    pct0 = 100;
    idle_cycles(4);

    @(posedge clk); #1;
    set_in(2'b10, 2'b10, '0, AW'(5), 16'h0000, 16'hffff);
    @(posedge clk); #1;
    set_in(2'b10, 2'b10, '0, AW'(5), 16'hffff, 16'h00ff);
    @(posedge clk); #1;
    set_in(2'b01, 2'b00, AW'(5), '0, '0, '0);
    @(posedge clk); #1;
    bus.v_i = 2'b00;
    @(negedge clk);
    chk("masked_v", bus.resp_v_o[0], 1'b1);
    chk("masked_data", bus.resp_data_o[W-1:0], 16'h00ff);
    idle_cycles(4);

    @(posedge clk); #1;
    set_in(2'b01, 2'b00, AW'(3), '0, '0, '0);
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b1;
    bus.v_i = 2'b00;
    q0.delete();
    q1.delete();
    reset_checks();
    @(posedge clk); #1;
    chk("midrst_resp_v", bus.resp_v_o, 2'b00);
    rst = 1'b0;
    post_reset();
    @(posedge clk); #1;
    chk("after_rst_resp_v", bus.resp_v_o, 2'b00);
    pct0 = 60;
    pct1 = 60;
    mon_en = 1'b1;

    rand_cycles(500);
    pct0 = 100;
    pct1 = 100;
    idle_cycles(6);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
